// File: rtl/dmem_arbiter_if.sv
// Request and memory bus bundle for dmem_arbiter. The arbiter uses the slave modport.
// The requesters and data_memory use the master modport. err0/err1 exist only with DMEM_ARB_ALIGN_CHECK_EN.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;
   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;
   logic [ADDR_W-1:0] mem_A;
   logic [DATA_W-1:0] mem_WriteData;
   logic              mem_WE;
   logic [DATA_W-1:0] mem_ReadData;
   logic              busy;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic              err0;
   logic              err1;
`endif

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_ReadData,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      output err0, err1,
`endif
      output ack0, rdata0, ack1, rdata1,
      output mem_A, mem_WriteData, mem_WE, busy
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_ReadData,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      input  err0, err1,
`endif
      input  ack0, rdata0, ack1, rdata1,
      input  mem_A, mem_WriteData, mem_WE, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and IDLE/ACCESS/DONE sequencer in front of single-port data_memory.
// Optional DMEM_ARB_ALIGN_CHECK_EN blocks misaligned accesses and reports them on err0/err1.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic              r_grant_q;
   logic              r_last_grant;
   logic              r_we_q;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_wdata_q;
   logic              r_mem_we;
   logic              r_ack0;
   logic              r_ack1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_busy;

   logic              w_load;
   logic              w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_sel_ok;
   logic              w_q_ok;
   logic [DATA_W-1:0] w_rd;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic              r_err0;
   logic              r_err1;

   function automatic logic is_aligned(input logic [1:0] a);
      return (a == 2'b00);
   endfunction

   assign w_sel_ok = is_aligned(w_sel_addr[1:0]);
   assign w_q_ok   = is_aligned(r_addr_q[1:0]);
   assign bus.err0 = r_err0;
   assign bus.err1 = r_err1;
`else
   assign w_sel_ok = 1'b1;
   assign w_q_ok   = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and arbitration: on a tie the port that did not win last time goes first
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_win        = r_grant_q;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0 && bus.req1) begin
               w_win        = ~r_last_grant;
               w_load       = 1'b1;
               w_next_state = ST_ACCESS;
            end else if (bus.req0) begin
               w_win        = 1'b0;
               w_load       = 1'b1;
               w_next_state = ST_ACCESS;
            end else if (bus.req1) begin
               w_win        = 1'b1;
               w_load       = 1'b1;
               w_next_state = ST_ACCESS;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACCESS: w_next_state = ST_DONE;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Steer the winning port's request fields
   always_comb begin
      w_sel_we    = bus.we0;
      w_sel_addr  = bus.addr0;
      w_sel_wdata = bus.wdata0;
      if (w_win) begin
         w_sel_we    = bus.we1;
         w_sel_addr  = bus.addr1;
         w_sel_wdata = bus.wdata1;
      end else begin
         w_sel_we    = bus.we0;
         w_sel_addr  = bus.addr0;
         w_sel_wdata = bus.wdata0;
      end
   end

   // A blocked misaligned access returns zero instead of memory contents
   always_comb begin
      w_rd = {DATA_W{1'b0}};
      if (w_q_ok) begin
         w_rd = bus.mem_ReadData;
      end else begin
         w_rd = {DATA_W{1'b0}};
      end
   end

   // Datapath and output registers; mem_WE is registered so reset clears it asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant_q    <= 1'b0;
         r_last_grant <= 1'b1;
         r_we_q       <= 1'b0;
         r_addr_q     <= {ADDR_W{1'b0}};
         r_wdata_q    <= {DATA_W{1'b0}};
         r_mem_we     <= 1'b0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rdata0     <= {DATA_W{1'b0}};
         r_rdata1     <= {DATA_W{1'b0}};
         r_busy       <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
`endif
      end else begin
         r_mem_we <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= {DATA_W{1'b0}};
         r_rdata1 <= {DATA_W{1'b0}};
         r_busy   <= (w_next_state != ST_IDLE);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
`endif
         if (w_load) begin
            r_grant_q    <= w_win;
            r_last_grant <= w_win;
            r_we_q       <= w_sel_we;
            r_addr_q     <= w_sel_addr;
            r_wdata_q    <= w_sel_wdata;
            r_mem_we     <= w_sel_we & w_sel_ok;
         end else begin
            r_grant_q    <= r_grant_q;
            r_last_grant <= r_last_grant;
         end
         if (r_state == ST_ACCESS) begin
            if (r_grant_q) begin
               r_ack1   <= 1'b1;
               r_rdata1 <= w_rd;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
               r_err1   <= ~w_q_ok;
`endif
            end else begin
               r_ack0   <= 1'b1;
               r_rdata0 <= w_rd;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
               r_err0   <= ~w_q_ok;
`endif
            end
         end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
         end
      end
   end

   assign bus.mem_A         = r_addr_q;
   assign bus.mem_WriteData = r_wdata_q;
   assign bus.mem_WE        = r_mem_we & r_we_q;
   assign bus.ack0          = r_ack0;
   assign bus.ack1          = r_ack1;
   assign bus.rdata0        = r_rdata0;
   assign bus.rdata1        = r_rdata1;
   assign bus.busy          = r_busy;

endmodule
